// File: rtl/ret_addr_stack.sv
// Return-address stack for the 16-bit pipelined core: pushes on CALL in EX,
// pops on RET in EX, and presents the RET target combinationally.

`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

module ret_addr_stack #(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] RET_OFS = 16'd2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                ex_instr,
    input  logic [15:0]                ex_pc,
    input  logic                       ex_valid,
    input  logic                       stall,
    output logic [15:0]                ret_pc,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ZERO = '0;
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

    logic [15:0]    r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           r_underflow;

    logic [3:0]     w_opcode;
    logic           w_push;
    logic           w_pop;
    logic           w_nonempty;
    logic           w_full;
    logic [SPW-1:0] w_top_idx;
    logic [15:0]    w_ret_addr;

    assign w_opcode   = ex_instr[15:12];
    assign w_push     = ex_valid & ~stall & (w_opcode == `CALL);
    assign w_pop      = ex_valid & ~stall & (w_opcode == `RET);
    assign w_nonempty = (r_count != CNT_ZERO);
    assign w_full     = (r_count == CNT_MAX);
    assign w_top_idx  = r_sp - SP_ONE;
    assign w_ret_addr = ex_pc + RET_OFS;

    // Storage is never cleared; reset only suppresses a coincident push.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_sp] <= w_ret_addr;
        end
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_push) begin
            r_sp <= r_sp + SP_ONE;
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_pop) begin
            if (w_nonempty) begin
                r_sp    <= r_sp - SP_ONE;
                r_count <= r_count - CW'(1);
            end else begin
                r_underflow <= 1'b1;
            end
        end else begin
            r_sp <= r_sp;
        end
    end

    // Pre-pop top of stack drives the next-PC mux in the RET cycle itself.
    always_comb begin
        ret_pc = 16'h0000;
        if (w_nonempty) begin
            ret_pc = r_mem[w_top_idx];
        end else begin
            ret_pc = 16'h0000;
        end
    end

    assign empty     = ~w_nonempty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack at DEPTH=8 and DEPTH=4.

`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

module tb_ret_addr_stack;

    logic        clk;
    logic        rst_n;
    logic [15:0] ex_instr;
    logic [15:0] ex_pc;
    logic        ex_valid;
    logic        stall;

    logic [15:0] ret_pc8, ret_pc4;
    logic        empty8, empty4, full8, full4;
    logic [3:0]  count8;
    logic [2:0]  count4;
    logic        ovf8, ovf4, udf8, udf4;

    int n_checks;
    int n_errors;

    ret_addr_stack #(.DEPTH(8), .RET_OFS(16'd2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_valid(ex_valid), .stall(stall), .ret_pc(ret_pc8),
        .empty(empty8), .full(full8), .count(count8),
        .overflow(ovf8), .underflow(udf8)
    );

    ret_addr_stack #(.DEPTH(4), .RET_OFS(16'd2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_valid(ex_valid), .stall(stall), .ret_pc(ret_pc4),
        .empty(empty4), .full(full4), .count(count4),
        .overflow(ovf4), .underflow(udf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks made before the next edge.
    task automatic drive(input logic v, input logic s, input logic [3:0] op, input logic [15:0] pc);
        ex_valid = v;
        stall    = s;
        ex_instr = {op, 12'h123};
        ex_pc    = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle();
        do_reset();

        chk("rst_empty",     {31'd0, empty8}, 32'd1);
        chk("rst_full",      {31'd0, full8},  32'd0);
        chk("rst_count",     {28'd0, count8}, 32'd0);
        chk("rst_ret_pc",    {16'd0, ret_pc8}, 32'h0000);
        chk("rst_overflow",  {31'd0, ovf8},   32'd0);
        chk("rst_underflow", {31'd0, udf8},   32'd0);

        // Three calls then three returns.
        drive(1'b1, 1'b0, `CALL, 16'h0100); tick();
        drive(1'b1, 1'b0, `CALL, 16'h0200); tick();
        drive(1'b1, 1'b0, `CALL, 16'h0300); tick();
        drive(1'b1, 1'b0, 4'h1, 16'h0400);  tick();
        chk("call3_count", {28'd0, count8}, 32'd3);
        chk("call3_ret_pc", {16'd0, ret_pc8}, 32'h0302);
        drive(1'b1, 1'b0, `RET, 16'h0500);
        chk("ret1_pc", {16'd0, ret_pc8}, 32'h0302);
        tick();
        chk("ret2_pc", {16'd0, ret_pc8}, 32'h0202);
        tick();
        chk("ret3_pc", {16'd0, ret_pc8}, 32'h0102);
        tick();
        idle();
        chk("ret_all_empty", {31'd0, empty8}, 32'd1);
        chk("ret_all_udf",   {31'd0, udf8},   32'd0);

        // Overflow and underflow on the 4-deep instance.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, `CALL, 16'(i * 16)); tick();
        end
        idle();
        chk("d4_full",     {31'd0, full4},  32'd1);
        chk("d4_count",    {29'd0, count4}, 32'd4);
        chk("d4_overflow", {31'd0, ovf4},   32'd1);
        chk("d8_no_ovf",   {31'd0, ovf8},   32'd0);
        drive(1'b1, 1'b0, `RET, 16'h0000);
        chk("d4_pop1", {16'd0, ret_pc4}, 32'h0052); tick();
        chk("d4_pop2", {16'd0, ret_pc4}, 32'h0042); tick();
        chk("d4_pop3", {16'd0, ret_pc4}, 32'h0032); tick();
        chk("d4_pop4", {16'd0, ret_pc4}, 32'h0022); tick();
        chk("d4_pop5_pre", {16'd0, ret_pc4}, 32'h0000);
        chk("d4_udf_pre",  {31'd0, udf4},    32'd0);
        tick();
        idle();
        chk("d4_underflow", {31'd0, udf4},   32'd1);
        chk("d4_udf_ret",   {16'd0, ret_pc4}, 32'h0000);
        chk("d4_udf_count", {29'd0, count4}, 32'd0);

        // Stalled CALL acts once; bubble CALL does nothing.
        do_reset();
        drive(1'b1, 1'b1, `CALL, 16'h1234);
        tick(); tick(); tick();
        chk("stall_no_push", {28'd0, count8}, 32'd0);
        drive(1'b1, 1'b0, `CALL, 16'h1234); tick();
        idle();
        chk("stall_count", {28'd0, count8}, 32'd1);
        chk("stall_ret_pc", {16'd0, ret_pc8}, 32'h1236);
        drive(1'b0, 1'b0, `CALL, 16'h5555); tick();
        chk("bubble_count", {28'd0, count8}, 32'd1);
        chk("bubble_ret_pc", {16'd0, ret_pc8}, 32'h1236);
        drive(1'b1, 1'b1, `RET, 16'h0000); tick();
        chk("stall_ret_count", {28'd0, count8}, 32'd1);

        // Wraparound return address, then reset beats a coincident CALL.
        do_reset();
        drive(1'b1, 1'b0, `RET, 16'h0000); tick();
        drive(1'b1, 1'b0, `CALL, 16'hFFFF); tick();
        idle();
        chk("wrap_ret_pc", {16'd0, ret_pc8}, 32'h0001);
        chk("wrap_udf",    {31'd0, udf8},    32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, `CALL, 16'h2000); tick();
        end
        chk("pre_rst_ovf4", {31'd0, ovf4}, 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, `CALL, 16'h3000); tick();
        rst_n = 1'b1;
        idle();
        chk("rst_call_count", {28'd0, count8}, 32'd0);
        chk("rst_call_empty", {31'd0, empty8}, 32'd1);
        chk("rst_call_ret",   {16'd0, ret_pc8}, 32'h0000);
        chk("rst_call_udf",   {31'd0, udf8},   32'd0);
        chk("rst_call_ovf4",  {31'd0, ovf4},   32'd0);
        chk("rst_call_cnt4",  {29'd0, count4}, 32'd0);
        tick();
        chk("post_rst_count", {28'd0, count8}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack for the 16-bit pipelined core; the supplier of the RET target that next-PC selection currently leaves undefined.
- Observes the instruction in EX: on CALL it pushes the return address; on RET it pops and presents the target combinationally in the same cycle, for the next-PC mux.
- Circular storage: overflow silently discards the oldest entry; underflow is flagged.

Parameters:
- DEPTH, 8, number of return-address entries; power of two, at least 2.
- RET_OFS, 2, added to the CALL's PC to form the return address: skips the CALL and its delay slot.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_instr  in  16  instruction in EX; [15:12] compared against `CALL / `RET from opcode.h.
- ex_pc  in  16  PC of the instruction in EX.
- ex_valid  in  1  EX holds a real instruction (0 = bubble/flushed).
- stall  in  1  pipeline hazard; EX instruction will be re-presented next cycle.
- ret_pc  out  16  current top-of-stack (the RET target).
- empty  out  1  no valid entries.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (rst_n low at a rising edge):
  - sp = 0, count = 0, overflow = 0, underflow = 0.
  - Storage contents are not cleared.
  - Takes priority over any push or pop in the same cycle.
  - Reset mid-sequence discards all entries.
- Decode:
  - do_push = ex_valid & ~stall & (ex_instr[15:12] == `CALL).
  - do_pop = ex_valid & ~stall & (ex_instr[15:12] == `RET).
  - Both are mutually exclusive by construction.
  - While stall is high, no push or pop occurs, so a held CALL/RET acts exactly once, in the cycle after stall drops.
- Storage: mem[DEPTH] of 16 bits; sp is a log2(DEPTH)-bit write pointer wrapping modulo DEPTH; top entry = mem[sp-1 mod DEPTH].
- ret_pc:
  - Combinational.
  - Equals the top entry when count > 0; 16'h0000 when empty.
  - Valid in the same cycle the RET is in EX; zero-cycle latency from the registered state.
  - Reflects the pre-pop value during the RET cycle.
- Push:
  - mem[sp] <= ex_pc + RET_OFS, modulo 2^16 (16'hFFFF + 2 = 16'h0001).
  - sp <= sp + 1 mod DEPTH.
  - If count < DEPTH, count increments; otherwise count holds at DEPTH, overflow <= 1, and the oldest entry is overwritten.
- Pop:
  - If count > 0: sp <= sp - 1 mod DEPTH, count decrements.
  - If count == 0: sp and count unchanged, underflow <= 1, ret_pc stays 16'h0000.
- New state is visible on ret_pc, count, empty and full one cycle after the push or pop.
- Non-CALL/RET instructions, bubbles and stalled cycles leave all state unchanged.
- overflow and underflow clear only on reset.

Test Plan:
- Reset → empty=1, full=0, count=0, ret_pc=0000, overflow=0, underflow=0.
- CALL at ex_pc 0100, then 0200, then 0300 (one per cycle) → count=3, ret_pc=0302.
  - Three RETs then give ret_pc 0302, 0202, 0102 in the respective RET cycles.
  - Afterwards empty=1.
- DEPTH=4; CALLs at ex_pc 0010, 0020, 0030, 0040, 0050 → full=1, count=4, overflow=1.
  - Four pops return 0052, 0042, 0032, 0022.
  - A fifth pop sets underflow=1 with ret_pc=0000.
- CALL held with stall=1 for 3 cycles, then stall=0 for one cycle at ex_pc 1234 → exactly one push; count=1, ret_pc=1236.
  - CALL with ex_valid=0 → no change.
- CALL at ex_pc FFFF → ret_pc=0001.
  - Assert rst_n=0 in the cycle of a following CALL → count=0, empty=1, the push is ignored, and the sticky flags are cleared.
